spi_fwm_sram_arb: RTL



---
 rtl/spi_fwm_sram_arb_if.sv | 38 +++
 rtl/spi_fwm_sram_arb.sv | 110 +++++++++++
 2 files changed

// File: rtl/spi_fwm_sram_arb_if.sv
// Bundle of the requester-side and memory-side signals of the buffer SRAM arbiter.
// slave: the arbiter's view. master: the view of the environment around it.
interface spi_fwm_sram_arb_if #(
    parameter int NumReq = 2,
    parameter int SramAw = 11,
    parameter int SramDw = 32
);
    // req_i/gnt_o: a requester raises req_i with write/addr/wdata and holds all of them
    // stable until gnt_o; the command transfers in the cycle where req_i and gnt_o are
    // both high. rvalid_o and mem_rvalid_i are one-cycle strobes with no back-pressure.
    logic [NumReq-1:0]        req_i;
    logic [NumReq-1:0]        write_i;
    logic [NumReq*SramAw-1:0] addr_i;
    logic [NumReq*SramDw-1:0] wdata_i;
    logic [NumReq-1:0]        gnt_o;
    logic [NumReq-1:0]        rvalid_o;
    logic [SramDw-1:0]        rdata_o;
    logic [1:0]               error_o;
    logic                     mem_req_o;
    logic                     mem_write_o;
    logic [SramAw-1:0]        mem_addr_o;
    logic [SramDw-1:0]        mem_wdata_o;
    logic                     mem_rvalid_i;
    logic [SramDw-1:0]        mem_rdata_i;
    logic [1:0]               mem_error_i;

    modport slave (
        input  req_i, write_i, addr_i, wdata_i, mem_rvalid_i, mem_rdata_i, mem_error_i,
        output gnt_o, rvalid_o, rdata_o, error_o, mem_req_o, mem_write_o, mem_addr_o,
               mem_wdata_o
    );

    modport master (
        output req_i, write_i, addr_i, wdata_i, mem_rvalid_i, mem_rdata_i, mem_error_i,
        input  gnt_o, rvalid_o, rdata_o, error_o, mem_req_o, mem_write_o, mem_addr_o,
               mem_wdata_o
    );
endinterface

// File: rtl/spi_fwm_sram_arb.sv
// Round-robin arbiter merging the SPI buffer-manager SRAM ports onto one single-port SRAM;
// read responses are steered back to their issuer through an in-order tag FIFO.
module spi_fwm_sram_arb #(
    parameter int NumReq         = 2,
    parameter int SramAw         = 11,
    parameter int SramDw         = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    spi_fwm_sram_arb_if.slave    bus
);
    localparam int PW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int TW = $clog2(MaxOutstanding);
    localparam int CW = TW + 1;

    logic [PW-1:0]     r_prio;
    logic [PW-1:0]     r_tag_q [MaxOutstanding];
    logic [TW-1:0]     r_wptr;
    logic [TW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_mem_req;
    logic              r_mem_write;
    logic [SramAw-1:0] r_mem_addr;
    logic [SramDw-1:0] r_mem_wdata;

    logic              w_pop;
    logic              w_push;
    logic              w_tag_full;
    logic              w_found;
    logic [NumReq-1:0] w_elig;
    logic [PW-1:0]     w_idx;
    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_prio_nxt;
    logic [PW-1:0]     w_head;

    // A pop in the same cycle frees a slot, so a read may be granted even at full count.
    assign w_pop      = bus.mem_rvalid_i && (r_count != '0);
    assign w_tag_full = (r_count == CW'(MaxOutstanding)) && !w_pop;
    assign w_elig     = bus.req_i & (bus.write_i | {NumReq{!w_tag_full}});

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_idx = PW'((int'(r_prio) + i) % NumReq);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_push     = w_found && !bus.write_i[w_win];
    assign w_prio_nxt = (int'(w_win) == NumReq - 1) ? '0 : w_win + PW'(1);
    assign w_head     = r_tag_q[r_rptr];

    // Combinational outputs are forced low while reset is held.
    assign bus.gnt_o    = (rst_ni && w_found) ? (NumReq'(1) << w_win) : '0;
    assign bus.rvalid_o = (rst_ni && w_pop) ? (NumReq'(1) << w_head) : '0;
    assign bus.rdata_o  = rst_ni ? bus.mem_rdata_i : '0;
    assign bus.error_o  = rst_ni ? bus.mem_error_i : '0;

    assign bus.mem_req_o   = r_mem_req;
    assign bus.mem_write_o = r_mem_write;
    assign bus.mem_addr_o  = r_mem_addr;
    assign bus.mem_wdata_o = r_mem_wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prio      <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                r_tag_q[i] <= '0;
            end
        end else begin
            r_mem_req <= w_found;
            if (w_found) begin
                r_prio      <= w_prio_nxt;
                r_mem_write <= bus.write_i[w_win];
                r_mem_addr  <= bus.addr_i[int'(w_win)*SramAw +: SramAw];
                r_mem_wdata <= bus.wdata_i[int'(w_win)*SramDw +: SramDw];
            end
            if (w_push) begin
                r_tag_q[r_wptr] <= w_win;
                r_wptr          <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Read data arriving with no read outstanding has no owner and is discarded.
    a_rvalid_has_tag : assert property (
        @(posedge clk_i) disable iff (!rst_ni) bus.mem_rvalid_i |-> (r_count != '0)
    ) else $error("mem_rvalid_i with empty tag FIFO");
endmodule
